// File: rtl/dma_trace_pkg.sv
// Shared types and constants for the DMA trace capture block.
// DMA_TRACE_TIMESTAMP_EN widens each stored word with a 32-bit timestamp.
package dma_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRETRIG  = 2'd1,
    ST_POSTTRIG = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int TS_W = 32;

`ifdef DMA_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Width of a stored/read word: probe plus optional timestamp in the top bits.
  function automatic int rd_w(input int data_w);
    return TS_EN ? data_w + TS_W : data_w;
  endfunction

endpackage

// File: rtl/dma_trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read-first read port.
module dma_trace_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  // NOTE: the storage array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking writes make a same-edge read of the write address return the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dma_trace_capture.sv
// Trigger-centred trace buffer for DMA probe words with pre/post-trigger history.
// Define DMA_TRACE_TIMESTAMP_EN to store a free-running 32-bit timestamp with each word.
module dma_trace_capture
  import dma_trace_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 10,
  localparam int RD_W   = rd_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [DATA_W-1:0] probe,
  input  logic              probe_valid,
  input  logic              trig,
  input  logic [ADDR_W-1:0] post_cnt,
  output logic [1:0]        state,
  output logic              trig_hit,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              wrapped,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [RD_W-1:0]   rd_data,
  output logic              rd_valid
);

  state_t            state_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] remaining;
  logic              capturing;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [RD_W-1:0]   wdata;

  assign capturing = (state_q == ST_PRETRIG) || (state_q == ST_POSTTRIG);
  // A sample arriving with arm is the first pre-trigger word of the new capture.
  assign we        = probe_valid && (arm || capturing);
  assign waddr     = arm ? '0 : wptr;
  assign state     = state_q;

`ifdef DMA_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  assign wdata = {ts, probe};
`else
  assign wdata = probe;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wptr      <= '0;
      remaining <= '0;
      trig_addr <= '0;
      trig_hit  <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      trig_hit <= 1'b0;
      if (arm) begin
        state_q <= ST_PRETRIG;
        wptr    <= {{(ADDR_W-1){1'b0}}, probe_valid};
        wrapped <= 1'b0;
      end else if (capturing && probe_valid) begin
        wptr <= wptr + 1'b1;
        if (wptr == '1) wrapped <= 1'b1;
        if (state_q == ST_PRETRIG) begin
          if (trig) begin
            trig_addr <= wptr;
            trig_hit  <= 1'b1;
            remaining <= post_cnt;
            state_q   <= (post_cnt == '0) ? ST_DONE : ST_POSTTRIG;
          end
        end else begin
          // Entry to POSTTRIG guarantees remaining >= 1 here.
          remaining <= remaining - 1'b1;
          if (remaining == {{(ADDR_W-1){1'b0}}, 1'b1}) state_q <= ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  dma_trace_ram #(
    .WIDTH (RD_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
